// File: rtl/vga_source_sequencer.sv
// vga_source_sequencer
// Frame-aligned video source selector for the VGA output path. Registers the
// HS/VS/RGB of the selected source onto the pins and changes source only on a
// VS edge of the source currently on the pins. After each change, RGB is forced
// black for BLANK_FRAMES frames of the new source.

module vga_source_sequencer #(
    parameter int NSRC         = 11,
    parameter int SELW         = 4,
    parameter int BLANK_FRAMES = 2,
    parameter bit SYNC_ACTIVE  = 1'b0,
    parameter int RST_SEL      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SELW-1:0]    req_sel,
    input  logic [NSRC-1:0]    src_hs,
    input  logic [NSRC-1:0]    src_vs,
    input  logic [NSRC*12-1:0] src_rgb,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic [SELW-1:0]    active_sel,
    output logic               switching,
    output logic               frame_tick
);

    localparam int              CW       = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [CW-1:0]   CNT_DONE = CW'(BLANK_FRAMES);
    localparam logic [SELW:0]   NSRC_LIM = (SELW + 1)'(NSRC);
    localparam logic [SELW-1:0] SEL_RST  = SELW'(RST_SEL);

    typedef enum logic [1:0] {
        ST_STEADY,
        ST_WAIT_VS,
        ST_BLANK
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] active_sel_q, active_sel_d;
    logic [SELW-1:0] target_q, target_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            blank_q, blank_d;
    logic            vs_prev_q;

    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic [11:0]     rgb_q, rgb_d;
    logic            tick_q, tick_d;
    logic            switching_q, switching_d;

    logic [11:0]     rgb_arr [NSRC];
    logic            vs_cur;
    logic            vs_edge;
    logic            req_valid;
    logic [CW-1:0]   cnt_inc;

    for (genvar i = 0; i < NSRC; i++) begin : g_rgb
        assign rgb_arr[i] = src_rgb[12*i +: 12];
    end

    assign vs_cur    = src_vs[active_sel_q];
    assign vs_edge   = (vs_cur == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
    assign req_valid = {1'b0, req_sel} < NSRC_LIM;
    assign cnt_inc   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;

    // Control state: FSM, selected/target source, frame counter, VS history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_STEADY;
            active_sel_q <= SEL_RST;
            target_q     <= SEL_RST;
            cnt_q        <= '0;
            blank_q      <= 1'b0;
            vs_prev_q    <= SYNC_ACTIVE;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            blank_q      <= blank_d;
            // Sampling the VS of the next-cycle source keeps the history aligned
            // with whichever source is selected, so a switch never fakes an edge.
            vs_prev_q    <= src_vs[active_sel_d];
        end
    end

    // Next-state decisions: request handling, switch at VS edge, blank frame count
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        target_d     = target_q;
        cnt_d        = cnt_q;
        blank_d      = blank_q;
        case (state_q)
            ST_STEADY: begin
                if (req_valid && (req_sel != active_sel_q)) begin
                    target_d = req_sel;
                    state_d  = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (req_valid && (req_sel == active_sel_q)) begin
                    target_d = active_sel_q;
                    state_d  = ST_STEADY;
                    blank_d  = 1'b0;
                end else begin
                    if (req_valid) begin
                        target_d = req_sel;
                    end
                    if (vs_edge) begin
                        // target_d already carries a same-cycle request, so it wins
                        active_sel_d = target_d;
                        cnt_d        = '0;
                        if (BLANK_FRAMES > 0) begin
                            state_d = ST_BLANK;
                            blank_d = 1'b1;
                        end else begin
                            state_d = ST_STEADY;
                            blank_d = 1'b0;
                        end
                    end
                end
            end
            ST_BLANK: begin
                if (req_valid && (req_sel != active_sel_q)) begin
                    target_d = req_sel;
                    state_d  = ST_WAIT_VS;
                end else if (vs_edge) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_DONE) begin
                        state_d = ST_STEADY;
                        blank_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_STEADY;
                blank_d = 1'b0;
            end
        endcase
    end

    // Pin values: pass the selected source through, black RGB while blanked
    always_comb begin
        hs_d        = src_hs[active_sel_q];
        vs_d        = vs_cur;
        rgb_d       = blank_q ? '0 : rgb_arr[active_sel_q];
        tick_d      = (vs_d == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);
        switching_d = (state_d != ST_STEADY);
    end

    // Output registers driving the VGA pins and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q        <= ~SYNC_ACTIVE;
            vs_q        <= ~SYNC_ACTIVE;
            rgb_q       <= '0;
            tick_q      <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            rgb_q       <= rgb_d;
            tick_q      <= tick_d;
            switching_q <= switching_d;
        end
    end

    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign active_sel = active_sel_q;
    assign switching  = switching_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_source_sequencer.sv
// Testbench for vga_source_sequencer: free-running per-source frame generators,
// a frame-level reference model, directed scenarios and a randomized soak.

module tb_vga_source_sequencer;

    localparam int NSRC = 11;
    localparam int SELW = 4;
    localparam int BF   = 2;
    localparam bit ACT  = 1'b0;
    localparam int RST  = 0;

    localparam logic [19:0] RESET_VEC = {~ACT, ~ACT, 12'h000, SELW'(RST), 1'b0, 1'b0};

    logic               clk = 1'b0;
    logic               rst_n;
    logic [SELW-1:0]    req_sel;
    logic [NSRC-1:0]    src_hs;
    logic [NSRC-1:0]    src_vs;
    logic [NSRC*12-1:0] src_rgb;
    logic               vga_hs, vga_vs;
    logic [3:0]         vga_r, vga_g, vga_b;
    logic [SELW-1:0]    active_sel;
    logic               switching;
    logic               frame_tick;
    logic [19:0]        obs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_source_sequencer #(
        .NSRC(NSRC), .SELW(SELW), .BLANK_FRAMES(BF), .SYNC_ACTIVE(ACT), .RST_SEL(RST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_sel(req_sel),
        .src_hs(src_hs), .src_vs(src_vs), .src_rgb(src_rgb),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .active_sel(active_sel), .switching(switching), .frame_tick(frame_tick)
    );

    assign obs = {vga_hs, vga_vs, vga_r, vga_g, vga_b, active_sel, switching, frame_tick};

    // Source frame generators: VS active for the first 2 cycles of each frame
    int gcnt [NSRC];
    int gper [NSRC];

    task automatic init_gens();
        for (int i = 0; i < NSRC; i++) begin
            gper[i] = int'($urandom_range(12, 30));
            gcnt[i] = int'($urandom_range(0, gper[i] - 1));
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NSRC; i++) begin
            gcnt[i] = (gcnt[i] + 1) % gper[i];
            src_vs[i] = (gcnt[i] < 2) ? ACT : ~ACT;
            src_hs[i] = 1'($urandom_range(0, 1));
            src_rgb[12*i +: 12] = 12'($urandom);
        end
    endtask

    // Reference model: pending switch, frames of darkness left to wait out
    int   m_mode;   // 0 steady, 1 switch pending, 2 counting dark frames
    int   m_cur, m_tgt, m_left;
    bit   m_dark;
    logic m_prev;
    logic e_hs, e_vs, e_tick;
    logic [11:0] e_rgb;

    task automatic model_reset();
        m_mode = 0; m_cur = RST; m_tgt = RST; m_left = 0; m_dark = 0; m_prev = ACT;
        e_hs = ~ACT; e_vs = ~ACT; e_rgb = '0; e_tick = 1'b0;
    endtask

    task automatic model_clock();
        logic vs_now;
        bit   new_frame, valid;
        int   r;
        vs_now    = src_vs[m_cur];
        new_frame = (vs_now == ACT) && (m_prev != ACT);
        valid     = int'(req_sel) < NSRC;
        r         = int'(req_sel);
        e_tick    = (vs_now == ACT) && (e_vs != ACT);
        e_hs      = src_hs[m_cur];
        e_vs      = vs_now;
        e_rgb     = m_dark ? 12'h000 : src_rgb[12*m_cur +: 12];
        case (m_mode)
            0: if (valid && r != m_cur) begin m_tgt = r; m_mode = 1; end
            1: begin
                if (valid && r == m_cur) begin
                    m_mode = 0; m_dark = 0;
                end else begin
                    if (valid) m_tgt = r;
                    if (new_frame) begin
                        m_cur = m_tgt; m_left = BF;
                        m_mode = (BF > 0) ? 2 : 0;
                        m_dark = (BF > 0);
                    end
                end
            end
            default: begin
                if (valid && r != m_cur) begin
                    m_tgt = r; m_mode = 1;
                end else if (new_frame) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_mode = 0; m_dark = 0; end
                end
            end
        endcase
        m_prev = src_vs[m_cur];
    endtask

    function automatic logic [19:0] exp_vec();
        return {e_hs, e_vs, e_rgb, SELW'(m_cur), m_mode != 0, e_tick};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_sel = SELW'(RST);
        init_gens(); drive_inputs();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== RESET_VEC) begin
                n_err++; $display("FAIL reset cyc %0d: got %h want %h", i, obs, RESET_VEC);
            end
            drive_inputs();
        end
        rst_n = 1'b1; model_reset();
    endtask

    task automatic test_passthrough();
        logic [11:0] want;
        for (int i = 0; i < 8; i++) begin
            drive_inputs();
            want = (i == 0) ? 12'hABC : 12'($urandom);
            src_rgb[11:0] = want;
            tick();
            n_cmp++;
            if ({vga_r, vga_g, vga_b} !== want || obs !== exp_vec()) begin
                n_err++; $display("FAIL passthrough cyc %0d: got %h/%h want %h/%h", i,
                                  {vga_r, vga_g, vga_b}, obs, want, exp_vec());
            end
        end
    endtask

    task automatic test_switch();
        bit   done = 0, seen = 0;
        logic vs0_now = ACT, vs0_old = ACT;
        for (int i = 0; i < 40 && gcnt[0] != gper[0] / 2; i++) begin
            drive_inputs(); tick();
        end
        req_sel = 4'd3;
        for (int c = 0; c < 400 && !done; c++) begin
            drive_inputs();
            vs0_old = vs0_now; vs0_now = src_vs[0];
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL switch cyc %0d: got %h want %h", c, obs, exp_vec());
            end
            if (!seen && active_sel === 4'd3) begin
                seen = 1;
                n_cmp++;
                if (!(vs0_now == ACT && vs0_old != ACT)) begin
                    n_err++; $display("FAIL switch_align: src0 vs old/new got %b%b want %b%b",
                                      vs0_old, vs0_now, ~ACT, ACT);
                end
            end
            done = (m_mode == 0);
        end
        n_cmp++;
        if (!done || active_sel !== 4'd3 || switching !== 1'b0) begin
            n_err++; $display("FAIL switch_end: got active %0d sw %b want 3 0 (done %0d)",
                              active_sel, switching, done);
        end
    endtask

    task automatic test_retarget();
        bit done = 0;
        for (int c = 0; c < 400 && m_mode != 2; c++) begin
            req_sel = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'd7;
            drive_inputs(); tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL retarget_a cyc %0d: got %h want %h", c, obs, exp_vec());
            end
        end
        for (int c = 0; c < 400 && !done; c++) begin
            req_sel = ($urandom_range(0, 3) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'd5;
            drive_inputs(); tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL retarget_b cyc %0d: got %h want %h", c, obs, exp_vec());
            end
            if (active_sel === 4'd7) begin
                n_cmp++;
                if ({vga_r, vga_g, vga_b} !== 12'h000) begin
                    n_err++; $display("FAIL retarget_dark cyc %0d: got %h want 000",
                                      c, {vga_r, vga_g, vga_b});
                end
            end
            done = (m_mode == 0);
        end
        n_cmp++;
        if (!done || active_sel !== 4'd5) begin
            n_err++; $display("FAIL retarget_end: got active %0d want 5 (done %0d)", active_sel, done);
        end
    endtask

    task automatic test_cancel();
        for (int i = 0; i < 40 && gcnt[5] != gper[5] / 2; i++) begin
            drive_inputs(); tick();
        end
        req_sel = 4'd4;
        for (int c = 0; c < 60; c++) begin
            if (c == 3) req_sel = 4'd5;
            drive_inputs(); tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL cancel cyc %0d: got %h want %h", c, obs, exp_vec());
            end
        end
        n_cmp++;
        if (active_sel !== 4'd5 || switching !== 1'b0) begin
            n_err++; $display("FAIL cancel_end: got active %0d sw %b want 5 0", active_sel, switching);
        end
    endtask

    task automatic test_back_to_back();
        bit hit = 0;
        req_sel = 4'd8;
        for (int c = 0; c < 60 && !hit; c++) begin
            drive_inputs();
            if (gcnt[5] == 0 && m_mode == 1) begin
                req_sel = 4'd9; hit = 1;
            end
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL b2b cyc %0d: got %h want %h", c, obs, exp_vec());
            end
        end
        n_cmp++;
        if (!hit || active_sel !== 4'd9) begin
            n_err++; $display("FAIL b2b_win: got active %0d want 9 (hit %0d)", active_sel, hit);
        end
    endtask

    task automatic test_reset_mid_blank();
        int blank_cyc = 0;
        req_sel = 4'd2;
        for (int c = 0; c < 400 && blank_cyc < 3; c++) begin
            drive_inputs(); tick();
            if (m_mode == 2) blank_cyc++;
        end
        rst_n = 1'b0; #1;
        n_cmp++;
        if (obs !== RESET_VEC || blank_cyc < 3) begin
            n_err++; $display("FAIL rst_async: got %h want %h (blank %0d)", obs, RESET_VEC, blank_cyc);
        end
        for (int i = 0; i < 3; i++) begin
            drive_inputs();
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== RESET_VEC) begin
                n_err++; $display("FAIL rst_hold cyc %0d: got %h want %h", i, obs, RESET_VEC);
            end
        end
        rst_n = 1'b1; req_sel = SELW'(RST); model_reset();
        for (int c = 0; c < 30; c++) begin
            drive_inputs(); tick();
            n_cmp++;
            if (obs !== exp_vec() || switching !== 1'b0) begin
                n_err++; $display("FAIL rst_after cyc %0d: got %h want %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 24) == 0) req_sel = 4'($urandom_range(0, 15));
            drive_inputs(); tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random cyc %0d: got %h want %h", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        req_sel = '0; src_hs = '0; src_vs = '1; src_rgb = '0;
        test_reset();
        test_passthrough();
        test_switch();
        test_retarget();
        test_cancel();
        test_back_to_back();
        test_reset_mid_blank();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
